clk_step_ctrl: RTL and testbench

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

---
 rtl/clk_ctrl_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/clk_step_ctrl.sv | 116 +++++++++++
 tb/tb_clk_step_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg
//   Shared encodings for the CPU clock/step controller: FSM state codes,
//   MODE input codes, the default clock divisor and a helper that maps a
//   MODE value onto the FSM state it requests.
package clk_ctrl_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] mode_t;

  localparam state_t S_HALT = 2'b00;
  localparam state_t S_RUN  = 2'b01;
  localparam state_t S_STEP = 2'b10;
  localparam state_t S_FIRE = 2'b11;

  localparam mode_t MODE_HALT = 2'b00;
  localparam mode_t MODE_RUN  = 2'b01;
  localparam mode_t MODE_STEP = 2'b10;

  localparam logic [31:0] CLK_DEFAULT_DIV = 32'd50_000_000;

  // MODE 2'b11 is reserved and behaves like HALT.
  function automatic state_t mode_to_state(input mode_t mode);
    case (mode)
      MODE_RUN:  mode_to_state = S_RUN;
      MODE_STEP: mode_to_state = S_STEP;
      default:   mode_to_state = S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Synchronises a raw push-button into the clock domain, accepts a new
//   level only after it has been seen for DEBOUNCE_CYC consecutive cycles,
//   and emits a one-cycle pulse when a rising level is accepted.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   btn_raw    - raw asynchronous button input
//   rise_pulse - one-cycle pulse on each accepted press
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic rise_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  // cnt_q counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the count, so short glitches never land.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_pulse = rise_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl
//   Clock-enable generator for a teaching CPU. In RUN it produces a TICK
//   every divisor+1 cycles, in STEP it produces one TICK per debounced
//   button press, in HALT it produces none. CLK_OUT is a square wave that
//   toggles on every TICK. The divisor can be reloaded at run time.
// Ports:
//   CLK_IN   - system clock, rising edge
//   RST_N    - asynchronous active-low reset
//   MODE     - 00 HALT, 01 RUN, 10 STEP, 11 HALT
//   STEP_BTN - raw push-button for single stepping
//   DIV_VAL  - new divisor value
//   DIV_LOAD - one-cycle request to latch DIV_VAL
//   DIV_ACK  - one-cycle pulse when the latched divisor becomes active
//   TICK     - one-cycle clock enable for the CPU datapath
//   CLK_OUT  - divided square clock
//   STATE    - current FSM state
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DIV  = CLK_DEFAULT_DIV,
  parameter int          DEBOUNCE_CYC = 1_000_000
) (
  input  logic        CLK_IN,
  input  logic        RST_N,
  input  logic [1:0]  MODE,
  input  logic        STEP_BTN,
  input  logic [31:0] DIV_VAL,
  input  logic        DIV_LOAD,
  output logic        DIV_ACK,
  output logic        TICK,
  output logic        CLK_OUT,
  output logic [1:0]  STATE
);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_q, div_d;
  logic [31:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        clk_out_q, clk_out_d;
  logic        step_pulse;
  logic        wrap;
  logic        tick;
  logic        apply;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk       (CLK_IN),
    .rst_n     (RST_N),
    .btn_raw   (STEP_BTN),
    .rise_pulse(step_pulse)
  );

  // TICK and DIV_ACK depend only on registered state, so an asynchronous
  // reset drops them immediately, including in the middle of an S_FIRE cycle.
  // While running, a pending divisor waits for the wrap so the period in
  // progress finishes with the old value; otherwise it applies at once.
  always_comb begin
    wrap  = (state_q == S_RUN) && (cnt_q == div_q);
    tick  = wrap || (state_q == S_FIRE);
    apply = pending_q && ((state_q != S_RUN) || wrap);
  end

  // A step is only taken if the press arrives while parked in S_STEP and
  // MODE still asks for stepping; presses seen elsewhere are dropped.
  always_comb begin
    state_d = mode_to_state(MODE);
    if ((state_q == S_STEP) && (MODE == MODE_STEP) && step_pulse) begin
      state_d = S_FIRE;
    end
  end

  // The counter only advances in S_RUN, holding its value otherwise so RUN
  // resumes mid-period. Applying a divisor always restarts the period.
  // A load on the same cycle as an application leaves the new value pending
  // because application reads the shadow value from before the load.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_RUN) begin
      cnt_d = wrap ? '0 : cnt_q + 32'd1;
    end
    if (apply) begin
      cnt_d = '0;
    end

    div_d     = apply ? shadow_q : div_q;
    shadow_d  = DIV_LOAD ? DIV_VAL : shadow_q;
    pending_d = DIV_LOAD ? 1'b1 : (apply ? 1'b0 : pending_q);
    clk_out_d = clk_out_q ^ tick;
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_HALT;
      cnt_q     <= '0;
      div_q     <= DEFAULT_DIV;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign TICK    = tick;
  assign DIV_ACK = apply;
  assign CLK_OUT = clk_out_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl
//   Bench for clk_step_ctrl with DEFAULT_DIV=4 and DEBOUNCE_CYC=3.
//   A hand-derived vector table covers the RUN/HALT/divisor-reload timing,
//   short directed sequences cover stepping, glitches and asynchronous
//   reset, and a randomized run is compared against a behavioural model
//   that tracks cycles-remaining-to-tick and a sliding window of button
//   samples.
module tb_clk_step_ctrl;

  localparam logic [31:0] TB_DIV = 32'd4;
  localparam int          TB_DEB = 3;
  localparam logic [1:0]  M_HALT = 2'b00;
  localparam logic [1:0]  M_RUN  = 2'b01;
  localparam logic [1:0]  M_STEP = 2'b10;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  mode;
  logic        stepBtn;
  logic [31:0] divVal;
  logic        divLoad;
  logic        divAck;
  logic        tick;
  logic        clkOut;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  clk_step_ctrl #(
    .DEFAULT_DIV (TB_DIV),
    .DEBOUNCE_CYC(TB_DEB)
  ) dut (
    .CLK_IN  (clk),
    .RST_N   (rstN),
    .MODE    (mode),
    .STEP_BTN(stepBtn),
    .DIV_VAL (divVal),
    .DIV_LOAD(divLoad),
    .DIV_ACK (divAck),
    .TICK    (tick),
    .CLK_OUT (clkOut),
    .STATE   (state)
  );

  always #5 clk = ~clk;

  // Behavioural model: mRemain is the number of RUN cycles left before the
  // next tick (0 means this cycle ticks), pending divisors sit in a queue
  // of at most one entry, and the button is judged on its last TB_DEB
  // synchronised samples.
  int     mState;
  longint mRemain;
  longint mDiv;
  longint mPend[$];
  bit     mClk;
  bit     mLevel;
  bit     mPulse;
  bit     syncPipe[$];
  bit     sHist[$];

  function automatic int modeState(input logic [1:0] m);
    if (m == M_RUN) return 1;
    if (m == M_STEP) return 2;
    return 0;
  endfunction

  function automatic bit mTick();
    return ((mState == 1) && (mRemain == 0)) || (mState == 3);
  endfunction

  function automatic bit mAck();
    return (mPend.size() > 0) && ((mState != 1) || (mRemain == 0));
  endfunction

  function automatic void modelReset();
    mState  = 0;
    mDiv    = longint'(TB_DIV);
    mRemain = mDiv;
    mPend.delete();
    mClk    = 1'b0;
    mLevel  = 1'b0;
    mPulse  = 1'b0;
    syncPipe.delete();
    repeat (2) syncPipe.push_back(1'b0);
    sHist.delete();
    repeat (TB_DEB) sHist.push_back(1'b0);
  endfunction

  function automatic void modelEdge();
    bit t;
    bit a;
    bit s;
    bit acc;
    t = mTick();
    a = mAck();
    if (a) begin
      mDiv    = mPend.pop_front();
      mRemain = mDiv;
    end else if (mState == 1) begin
      mRemain = (mRemain == 0) ? mDiv : mRemain - 1;
    end
    if (divLoad) begin
      mPend.delete();
      mPend.push_back(longint'(divVal));
    end
    if (t) mClk = ~mClk;
    if ((mState == 2) && (modeState(mode) == 2) && mPulse) mState = 3;
    else mState = modeState(mode);
    s = syncPipe.pop_front();
    syncPipe.push_back(stepBtn);
    void'(sHist.pop_front());
    sHist.push_back(s);
    acc = 1'b1;
    foreach (sHist[k]) if (sHist[k] == mLevel) acc = 1'b0;
    mPulse = acc && !mLevel;
    if (acc) mLevel = ~mLevel;
  endfunction

  typedef struct {
    logic [1:0]  mode;
    logic        ld;
    logic [31:0] val;
    logic        expTick;
    logic        expAck;
    logic [1:0]  expState;
    logic        expClk;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic [1:0] m, input logic ld, input logic [31:0] v,
                                 input logic t, input logic a, input logic [1:0] st, input logic c);
    vec_t e;
    e.mode = m; e.ld = ld; e.val = v;
    e.expTick = t; e.expAck = a; e.expState = st; e.expClk = c;
    vecs.push_back(e);
  endfunction

  // Expected values after each edge, derived by hand from the timing rules.
  function automatic void buildTable();
    repeat (4) addVec(M_RUN, 0, 0, 0, 0, 2'd1, 0);
    addVec(M_RUN, 0, 0, 1, 0, 2'd1, 0);
    repeat (4) addVec(M_RUN, 0, 0, 0, 0, 2'd1, 1);
    addVec(M_RUN, 0, 0, 1, 0, 2'd1, 1);
    addVec(M_RUN, 0, 0, 0, 0, 2'd1, 0);
    addVec(M_RUN, 1, 1, 0, 0, 2'd1, 0);
    repeat (2) addVec(M_RUN, 0, 0, 0, 0, 2'd1, 0);
    addVec(M_RUN, 0, 0, 1, 1, 2'd1, 0);
    addVec(M_RUN, 0, 0, 0, 0, 2'd1, 1);
    addVec(M_RUN, 0, 0, 1, 0, 2'd1, 1);
    addVec(M_RUN, 0, 0, 0, 0, 2'd1, 0);
    addVec(M_RUN, 0, 0, 1, 0, 2'd1, 0);
    addVec(M_RUN, 0, 0, 0, 0, 2'd1, 1);
    addVec(M_HALT, 0, 0, 0, 0, 2'd0, 1);
    addVec(M_HALT, 1, 0, 0, 1, 2'd0, 1);
    addVec(M_HALT, 0, 0, 0, 0, 2'd0, 1);
    addVec(M_RUN, 0, 0, 1, 0, 2'd1, 1);
    addVec(M_RUN, 0, 0, 1, 0, 2'd1, 0);
    addVec(M_RUN, 0, 0, 1, 0, 2'd1, 1);
    addVec(M_RUN, 1, 4, 1, 1, 2'd1, 0);
    repeat (3) addVec(M_RUN, 0, 0, 0, 0, 2'd1, 1);
    repeat (21) addVec(M_HALT, 0, 0, 0, 0, 2'd0, 1);
    addVec(M_RUN, 0, 0, 0, 0, 2'd1, 1);
    addVec(M_RUN, 0, 0, 1, 0, 2'd1, 1);
    addVec(M_RUN, 0, 0, 0, 0, 2'd1, 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_tick"},  32'(tick),   32'(mTick()));
    checkOutput({tag, "_ack"},   32'(divAck), 32'(mAck()));
    checkOutput({tag, "_state"}, 32'(state),  32'(mState));
    checkOutput({tag, "_clk"},   32'(clkOut), 32'(mClk));
  endtask

  // Called at a falling edge; drives inputs, lets one rising edge pass,
  // advances the model for that edge and returns at the next falling edge.
  task automatic applyStimulus(input logic [1:0] inMode, input logic inLd,
                               input logic [31:0] inVal, input logic inBtn);
    mode    = inMode;
    divLoad = inLd;
    divVal  = inVal;
    stepBtn = inBtn;
    @(posedge clk);
    if (rstN) modelEdge();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tickCnt;
    int fireCnt;
    logic btn;

    rstN    = 1'b0;
    mode    = M_RUN;
    stepBtn = 1'b0;
    divVal  = '0;
    divLoad = 1'b0;
    modelReset();
    buildTable();

    #1;
    checkOutput("reset_tick",  32'(tick),   32'd0);
    checkOutput("reset_ack",   32'(divAck), 32'd0);
    checkOutput("reset_state", 32'(state),  32'd0);
    checkOutput("reset_clk",   32'(clkOut), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].mode, vecs[i].ld, vecs[i].val, 1'b0);
      checkOutput($sformatf("vec%0d_tick", i),  32'(tick),   32'(vecs[i].expTick));
      checkOutput($sformatf("vec%0d_ack", i),   32'(divAck), 32'(vecs[i].expAck));
      checkOutput($sformatf("vec%0d_state", i), 32'(state),  32'(vecs[i].expState));
      checkOutput($sformatf("vec%0d_clk", i),   32'(clkOut), 32'(vecs[i].expClk));
      checkModel("vec_model");
    end

    // Single step: a 5-cycle press gives exactly one S_FIRE cycle and tick.
    repeat (2) begin
      applyStimulus(M_STEP, 0, 0, 1'b0);
      checkModel("step_idle");
    end
    tickCnt = 0;
    fireCnt = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(M_STEP, 0, 0, (i < 5));
      checkModel("step_press");
      if (tick === 1'b1) tickCnt++;
      if (state === 2'b11) fireCnt++;
    end
    checkOutput("step_ticks", 32'(tickCnt), 32'd1);
    checkOutput("step_fire_cycles", 32'(fireCnt), 32'd1);
    checkOutput("step_state_end", 32'(state), 32'd2);

    // A 2-cycle glitch is shorter than the debounce window.
    tickCnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(M_STEP, 0, 0, (i < 2));
      checkModel("glitch");
      if (tick === 1'b1) tickCnt++;
    end
    checkOutput("glitch_ticks", 32'(tickCnt), 32'd0);

    // A press accepted in HALT must not fire once STEP is selected.
    tickCnt = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus((i < 6) ? M_HALT : M_STEP, 0, 0, (i < 9));
      checkModel("queued");
      if (tick === 1'b1) tickCnt++;
    end
    checkOutput("queued_ticks", 32'(tickCnt), 32'd0);

    // Asynchronous reset mid-period, then the default divisor again.
    repeat (3) begin
      applyStimulus(M_RUN, 0, 0, 1'b0);
      checkModel("pre_rst");
    end
    applyStimulus(M_RUN, 1, 2, 1'b0);
    checkModel("pre_rst_load");
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_tick",  32'(tick),   32'd0);
    checkOutput("async_rst_ack",   32'(divAck), 32'd0);
    checkOutput("async_rst_state", 32'(state),  32'd0);
    checkOutput("async_rst_clk",   32'(clkOut), 32'd0);
    @(negedge clk);
    checkOutput("rst_held_state", 32'(state), 32'd0);
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(M_RUN, 0, 0, 1'b0);
      checkOutput($sformatf("post_rst_tick%0d", i), 32'(tick), (i == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("post_rst_ack%0d", i), 32'(divAck), 32'd0);
      checkModel("post_rst");
    end

    // Randomized run against the model.
    btn = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rstN = 1'b0;
        #1;
        modelReset();
        checkModel("rnd_rst");
        @(negedge clk);
        rstN = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) btn = ~btn;
      applyStimulus(mode, ($urandom_range(0, 9) == 0), 32'($urandom_range(0, 6)), btn);
      checkModel("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
